reg_bank_writer: RTL and testbench

REG_BANK_WRITER -- requirements
Module: reg_bank_writer

---
 rtl/reg_bank_writer.sv | 127 ++++++++++++
 tb/tb_reg_bank_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: 16 x 32-bit register bank with single writes and
// auto-incrementing bursts of 1..16 words. Register 0 can be hard-wired to zero.
module reg_bank_writer #(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        burst_start,
  input  logic [3:0]  burst_len,
  output logic        busy,
  output logic        done,
  output logic [31:0] q0,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic [31:0] q4,
  output logic [31:0] q5,
  output logic [31:0] q6,
  output logic [31:0] q7,
  output logic [31:0] q8,
  output logic [31:0] q9,
  output logic [31:0] q10,
  output logic [31:0] q11,
  output logic [31:0] q12,
  output logic [31:0] q13,
  output logic [31:0] q14,
  output logic [31:0] q15
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_rem;
  logic        r_done;
  logic [31:0] r_q [16];

  logic        w_we;
  logic        w_upd;
  logic [3:0]  w_waddr;

  // Every state accepts beats; only a cycle under reset refuses them.
  assign wr_ready = ~rst;
  assign busy     = (r_state == BURST);
  assign done     = r_done;

  // Select the write target: wr_addr for single writes, the burst pointer in
  // BURST. A burst_start cycle is pure setup and never writes.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    case (r_state)
      IDLE:  w_we = wr_valid && !burst_start;
      BURST: begin
        w_we    = wr_valid;
        w_waddr = r_ptr;
      end
      default: w_we = 1'b0;
    endcase
    // A beat aimed at a hard-zero r0 is still consumed, it just stores nothing.
    w_upd = w_we && !(ZERO_R0 && (w_waddr == 4'd0));
  end

  // Register bank: at most one entry changes per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
    end else if (w_upd) begin
      r_q[w_waddr] <= wr_data;
    end
  end

  // Burst control FSM: pointer/remaining count, done pulse after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 4'd0;
      r_rem   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (burst_start) begin
            r_ptr   <= wr_addr;
            r_rem   <= burst_len;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (wr_valid) begin
            r_ptr <= r_ptr + 4'd1;
            if (r_rem == 4'd0) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_rem <= r_rem - 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q0  = r_q[0];
  assign q1  = r_q[1];
  assign q2  = r_q[2];
  assign q3  = r_q[3];
  assign q4  = r_q[4];
  assign q5  = r_q[5];
  assign q6  = r_q[6];
  assign q7  = r_q[7];
  assign q8  = r_q[8];
  assign q9  = r_q[9];
  assign q10 = r_q[10];
  assign q11 = r_q[11];
  assign q12 = r_q[12];
  assign q13 = r_q[13];
  assign q14 = r_q[14];
  assign q15 = r_q[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: two instances (r0 hard-zero and r0 writable) share
// stimulus; a queue-based model of pending burst addresses predicts all outputs.
module tb_reg_bank_writer;

  logic        clk = 1'b0;
  logic        rst, wr_valid, burst_start;
  logic [3:0]  wr_addr, burst_len;
  logic [31:0] wr_data;
  logic        rdy_z, busy_z, done_z, rdy_n, busy_n, done_n;
  logic [31:0] qz [16];
  logic [31:0] qn [16];

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [31:0] mz [16];
  logic [31:0] mn [16];
  int          bq [$];
  logic        m_done;

  always #5 clk = ~clk;

  reg_bank_writer #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_z), .wr_addr(wr_addr),
    .wr_data(wr_data), .burst_start(burst_start), .burst_len(burst_len),
    .busy(busy_z), .done(done_z),
    .q0(qz[0]), .q1(qz[1]), .q2(qz[2]), .q3(qz[3]), .q4(qz[4]), .q5(qz[5]),
    .q6(qz[6]), .q7(qz[7]), .q8(qz[8]), .q9(qz[9]), .q10(qz[10]), .q11(qz[11]),
    .q12(qz[12]), .q13(qz[13]), .q14(qz[14]), .q15(qz[15]));

  reg_bank_writer #(.ZERO_R0(1'b0)) dut_n (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_n), .wr_addr(wr_addr),
    .wr_data(wr_data), .burst_start(burst_start), .burst_len(burst_len),
    .busy(busy_n), .done(done_n),
    .q0(qn[0]), .q1(qn[1]), .q2(qn[2]), .q3(qn[3]), .q4(qn[4]), .q5(qn[5]),
    .q6(qn[6]), .q7(qn[7]), .q8(qn[8]), .q9(qn[9]), .q10(qn[10]), .q11(qn[11]),
    .q12(qn[12]), .q13(qn[13]), .q14(qn[14]), .q15(qn[15]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a burst is a queue of target addresses; each beat pops one.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin mz[i] = 32'h0; mn[i] = 32'h0; end
      bq.delete();
      m_done = 1'b0;
    end else begin
      int a;
      logic hit;
      m_done = 1'b0;
      hit = 1'b0;
      a = 0;
      if (bq.size() == 0) begin
        if (burst_start) begin
          for (int k = 0; k <= int'(burst_len); k++) bq.push_back((int'(wr_addr) + k) % 16);
        end else if (wr_valid) begin
          a = int'(wr_addr); hit = 1'b1;
        end
      end else if (wr_valid) begin
        a = bq.pop_front(); hit = 1'b1;
        if (bq.size() == 0) m_done = 1'b1;
      end
      if (hit) begin
        mn[a] = wr_data;
        if (a != 0) mz[a] = wr_data;
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    logic m_busy;
    m_busy = (bq.size() != 0);
    chk("ready_z", {31'd0, rdy_z}, {31'd0, ~rst});
    chk("ready_n", {31'd0, rdy_n}, {31'd0, ~rst});
    chk("busy_z", {31'd0, busy_z}, {31'd0, m_busy});
    chk("busy_n", {31'd0, busy_n}, {31'd0, m_busy});
    chk("done_z", {31'd0, done_z}, {31'd0, m_done});
    chk("done_n", {31'd0, done_n}, {31'd0, m_done});
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("qz[%0d]", i), qz[i], mz[i]);
      chk($sformatf("qn[%0d]", i), qn[i], mn[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                       input logic bs, input logic [3:0] bl);
    wr_valid = v; wr_addr = a; wr_data = d; burst_start = bs; burst_len = bl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    step(); step();
    rst = 1'b0;
    chk("lit_reset_q5", qz[5], 32'h0);
    chk("lit_reset_busy", {31'd0, busy_z}, 32'd0);

    // single write
    drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0); step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_single_q5", qz[5], 32'hDEADBEEF);
    chk("lit_single_mdl", mz[5], 32'hDEADBEEF);
    chk("lit_single_q4", qz[4], 32'h0);
    chk("lit_single_done", {31'd0, done_z}, 32'd0);
    step();

    // burst_start with wr_valid: setup only; then wrap burst 14,15,0,1
    drive(1'b1, 4'd14, 32'hAAAA5555, 1'b1, 4'd3); step();
    chk("lit_prio_busy", {31'd0, busy_z}, 32'd1);
    chk("lit_prio_q14", qz[14], 32'h0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'd7, 32'(k), 1'b1, 4'd0); step();
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_wrap_q14", qz[14], 32'd1);
    chk("lit_wrap_q15", qz[15], 32'd2);
    chk("lit_wrap_q0z", qz[0], 32'd0);
    chk("lit_wrap_q0n", qn[0], 32'd3);
    chk("lit_wrap_q1", qz[1], 32'd4);
    chk("lit_wrap_q7", qz[7], 32'd0);
    chk("lit_wrap_done", {31'd0, done_z}, 32'd1);
    chk("lit_wrap_busy", {31'd0, busy_z}, 32'd0);
    step();
    chk("lit_wrap_done_off", {31'd0, done_z}, 32'd0);

    // stalled 3-word burst at 8
    drive(1'b0, 4'd8, 32'h0, 1'b1, 4'd2); step();
    drive(1'b1, 4'd0, 32'h11, 1'b0, 4'd0); step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0); step(); step();
    chk("lit_stall_busy", {31'd0, busy_z}, 32'd1);
    drive(1'b1, 4'd0, 32'h22, 1'b0, 4'd0); step();
    drive(1'b1, 4'd0, 32'h33, 1'b0, 4'd0); step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_stall_q8", qz[8], 32'h11);
    chk("lit_stall_q9", qz[9], 32'h22);
    chk("lit_stall_q10", qz[10], 32'h33);
    chk("lit_stall_done", {31'd0, done_z}, 32'd1);
    step();

    // reset after 2 of 8 beats
    drive(1'b0, 4'd2, 32'h0, 1'b1, 4'd7); step();
    drive(1'b1, 4'd0, 32'h77, 1'b0, 4'd0); step(); step();
    rst = 1'b1; step();
    rst = 1'b0; drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_rst_q2", qz[2], 32'h0);
    chk("lit_rst_q5", qz[5], 32'h0);
    chk("lit_rst_busy", {31'd0, busy_z}, 32'd0);
    step();
    chk("lit_rst_nodone", {31'd0, done_z}, 32'd0);
    drive(1'b1, 4'd3, 32'hCAFEF00D, 1'b0, 4'd0); step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_rst_q3", qz[3], 32'hCAFEF00D);

    // full 16-word burst from 0
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd15); step();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'd9, 32'(k + 100), 1'b0, 4'd0); step();
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("lit_full_q0z", qz[0], 32'd0);
    chk("lit_full_q0n", qn[0], 32'd100);
    chk("lit_full_q1", qz[1], 32'd101);
    chk("lit_full_q15", qz[15], 32'd115);
    chk("lit_full_done", {31'd0, done_z}, 32'd1);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) < 7), 4'($urandom), $urandom,
            ($urandom_range(0, 7) == 0), 4'($urandom));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
